// File: rtl/quantum_pkg.sv
// Shared number formats for the quantum matrix datapath.
// Q1.35 reals, complex pairs, 2x2 complex matrices, saturation helper.
package quantum_pkg;

  localparam int NUMBER_BITS = 37;
  localparam int FRAC_BITS   = 35;
  localparam int PROD_BITS   = 2 * NUMBER_BITS;
  localparam int ACC_BITS    = PROD_BITS + 2;

  typedef logic signed [NUMBER_BITS-1:0] number_t;
  typedef logic signed [PROD_BITS-1:0]   prod_t;
  typedef logic signed [ACC_BITS-1:0]    acc_t;

  typedef struct packed {
    number_t re;
    number_t im;
  } cnum_t;

  typedef struct packed {
    prod_t re;
    prod_t im;
  } cprod_t;

  typedef cnum_t [0:1][0:1] matrix_t;

  localparam acc_t SAT_MAX =
    {{(ACC_BITS-NUMBER_BITS+1){1'b0}},
     {(NUMBER_BITS-1){1'b1}}};
  localparam acc_t SAT_MIN =
    {{(ACC_BITS-NUMBER_BITS+1){1'b1}},
     {(NUMBER_BITS-1){1'b0}}};

  // Clamp a rescaled wide value into one Q1.35 number.
  function automatic number_t sat_number(input acc_t v);
    number_t r;
    if (v > SAT_MAX)
      r = {1'b0, {(NUMBER_BITS-1){1'b1}}};
    else if (v < SAT_MIN)
      r = {1'b1, {(NUMBER_BITS-1){1'b0}}};
    else
      r = v[NUMBER_BITS-1:0];
    return r;
  endfunction

endpackage

// File: rtl/complex_mul.sv
// Full-precision complex multiplier with one output register.
// Four real products, no control; the product register lives here.
module complex_mul
  import quantum_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  cnum_t  x,
  input  cnum_t  y,
  output cprod_t p
);

  prod_t  rr, ii, ri, ir;
  cprod_t p_q;

  // Sign-extend operands first so each real product is exact.
  always_comb begin
    rr = prod_t'(x.re) * prod_t'(y.re);
    ii = prod_t'(x.im) * prod_t'(y.im);
    ri = prod_t'(x.re) * prod_t'(y.im);
    ir = prod_t'(x.im) * prod_t'(y.re);
  end

  // Register the combined real and imaginary parts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q.re <= rr - ii;
      p_q.im <= ri + ir;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/mtx_mult_sequencer.sv
// 2x2 complex matrix product through one shared complex multiplier.
// Eight products issued in order, accumulated in pairs, saturated.
module mtx_mult_sequencer
  import quantum_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  matrix_t a_mtx,
  input  matrix_t b_mtx,
  output logic    busy,
  output logic    done,
  output matrix_t result_mtx
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic       state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [2:0] k_prev;
  matrix_t    a_q, a_d;
  matrix_t    b_q, b_d;
  matrix_t    res_q, res_d;
  acc_t       acc_re_q, acc_re_d;
  acc_t       acc_im_q, acc_im_d;
  logic       done_q, done_d;

  cnum_t  x, y;
  cprod_t p;
  acc_t   sum_re, sum_im;
  cnum_t  c_new;

  // Select the operand pair for the step currently being issued.
  always_comb begin
    x = a_q[k_q[2]][k_q[0]];
    y = b_q[k_q[0]][k_q[1]];
  end

  complex_mul u_mul (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .y    (y),
    .p    (p)
  );

  // Pair sum, floor rescale and clamp of the step whose product is in P.
  always_comb begin
    k_prev   = k_q[2:0] - 3'd1;
    sum_re   = acc_re_q + acc_t'(p.re);
    sum_im   = acc_im_q + acc_t'(p.im);
    c_new.re = sat_number(sum_re >>> FRAC_BITS);
    c_new.im = sat_number(sum_im >>> FRAC_BITS);
  end

  // Sequencer next state: latch on start, then issue/accumulate.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_mtx;
          b_d     = b_mtx;
          k_d     = 4'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (k_q != 4'd0) begin
          if (!k_prev[0]) begin
            acc_re_d = acc_t'(p.re);
            acc_im_d = acc_t'(p.im);
          end else begin
            res_d[k_prev[2]][k_prev[1]] = c_new;
          end
        end
        if (k_q == 4'd8) begin
          k_d     = 4'd0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any run and clears the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign result_mtx = res_q;

endmodule

// File: tb/tb_mtx_mult_sequencer.sv
// Directed bench for the 2x2 complex matrix sequencer.
// Scenario tasks with hand-computed expected matrices.
module tb_mtx_mult_sequencer;
  import quantum_pkg::*;

  logic    clk;
  logic    reset;
  logic    start;
  matrix_t a_mtx;
  matrix_t b_mtx;
  logic    busy;
  logic    done;
  matrix_t result_mtx;

  int n_checks;
  int n_fail;

  localparam longint ONE  = 64'sd34359738368;
  localparam longint H0   = 64'sd24296004000;
  localparam longint H1   = 64'sd24296004001;
  localparam longint H2   = 64'sd24296004002;
  localparam longint H3   = 64'sd24296004003;
  localparam longint QMAX = 64'sd68719476735;
  localparam longint QMIN = -64'sd68719476736;

  mtx_mult_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_mtx     (a_mtx),
    .b_mtx     (b_mtx),
    .busy      (busy),
    .done      (done),
    .result_mtx(result_mtx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic matrix_t mk(
    input longint r00, input longint r01,
    input longint r10, input longint r11,
    input longint i00, input longint i01,
    input longint i10, input longint i11);
    matrix_t m;
    m[0][0].re = 37'(r00);
    m[0][1].re = 37'(r01);
    m[1][0].re = 37'(r10);
    m[1][1].re = 37'(r11);
    m[0][0].im = 37'(i00);
    m[0][1].im = 37'(i01);
    m[1][0].im = 37'(i10);
    m[1][1].im = 37'(i11);
    return m;
  endfunction

  // Start one run from idle; returns cycles to done and busy cycles.
  task automatic launch(input matrix_t a, input matrix_t b,
                        output int lat, output int busy_n);
    a_mtx = a;
    b_mtx = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a_mtx  = '0;
    b_mtx  = '0;
    busy_n = busy ? 1 : 0;
    lat    = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a_mtx = '0;
    b_mtx = '0;
    #12;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b exp 0", done);
    end
    n_checks++;
    if (result_mtx !== '0) begin
      n_fail++;
      $display("FAIL reset_result got %h exp 0", result_mtx);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_identity();
    matrix_t id;
    int lat, bn;
    id = mk(ONE, 0, 0, ONE, 0, 0, 0, 0);
    launch(id, id, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL ident_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (bn !== 9) begin
      n_fail++;
      $display("FAIL ident_busy_cycles got %0d exp 9", bn);
    end
    n_checks++;
    if (result_mtx !== id) begin
      n_fail++;
      $display("FAIL ident_result got %h exp %h", result_mtx, id);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ident_done_pulse got %b exp 0", done);
    end
  endtask

  task automatic test_hadamard();
    matrix_t h, exp;
    int lat, bn;
    h   = mk(H0, H1, H2, -H3, 0, 0, 0, 0);
    exp = mk(64'sd34359738370, -64'sd3, -64'sd3,
             64'sd34359738374, 0, 0, 0, 0);
    launch(h, h, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL hada_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (result_mtx !== exp) begin
      n_fail++;
      $display("FAIL hada_result got %h exp %h", result_mtx, exp);
    end
  endtask

  task automatic test_saturation();
    matrix_t mx, mn;
    int lat, bn;
    mx = mk(QMAX, QMAX, QMAX, QMAX, 0, 0, 0, 0);
    mn = mk(QMIN, QMIN, QMIN, QMIN, 0, 0, 0, 0);
    launch(mx, mx, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL sat_pos_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (result_mtx !== mx) begin
      n_fail++;
      $display("FAIL sat_pos_result got %h exp %h", result_mtx, mx);
    end
    launch(mx, mn, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL sat_neg_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (result_mtx !== mn) begin
      n_fail++;
      $display("FAIL sat_neg_result got %h exp %h", result_mtx, mn);
    end
  endtask

  task automatic test_complex();
    matrix_t id, ji, neg;
    int lat, bn;
    id  = mk(ONE, 0, 0, ONE, 0, 0, 0, 0);
    ji  = mk(0, 0, 0, 0, ONE, 0, 0, ONE);
    neg = mk(-ONE, 0, 0, -ONE, 0, 0, 0, 0);
    launch(ji, ji, lat, bn);
    n_checks++;
    if (result_mtx !== neg) begin
      n_fail++;
      $display("FAIL jj_result got %h exp %h", result_mtx, neg);
    end
    launch(id, ji, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL ij_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (result_mtx !== ji) begin
      n_fail++;
      $display("FAIL ij_result got %h exp %h", result_mtx, ji);
    end
  endtask

  task automatic test_handshake();
    matrix_t id;
    int lat, ndone;
    id    = mk(ONE, 0, 0, ONE, 0, 0, 0, 0);
    a_mtx = id;
    b_mtx = id;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_mtx = mk(5, 6, 7, 8, 1, 2, 3, 4);
    b_mtx = a_mtx;
    lat   = -1;
    ndone = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1;
      start = (n == 2);
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL hs_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL hs_done_count got %0d exp 1", ndone);
    end
    n_checks++;
    if (result_mtx !== id) begin
      n_fail++;
      $display("FAIL hs_result got %h exp %h", result_mtx, id);
    end
    a_mtx = '0;
    b_mtx = '0;
  endtask

  task automatic test_back_to_back();
    matrix_t id, h, ji;
    int lat1, lat2;
    id = mk(ONE, 0, 0, ONE, 0, 0, 0, 0);
    h  = mk(H0, H1, H2, -H3, 0, 0, 0, 0);
    ji = mk(0, 0, 0, 0, ONE, 0, 0, ONE);
    a_mtx = id;
    b_mtx = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    b_mtx = ji;
    lat1  = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat1 = n;
        break;
      end
    end
    n_checks++;
    if (lat1 !== 9) begin
      n_fail++;
      $display("FAIL b2b_lat1 got %0d exp 9", lat1);
    end
    n_checks++;
    if (result_mtx !== h) begin
      n_fail++;
      $display("FAIL b2b_res1 got %h exp %h", result_mtx, h);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart busy %b done %b exp 1 0",
               busy, done);
    end
    lat2 = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat2 = n;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat2 !== 9) begin
      n_fail++;
      $display("FAIL b2b_lat2 got %0d exp 9", lat2);
    end
    n_checks++;
    if (result_mtx !== ji) begin
      n_fail++;
      $display("FAIL b2b_res2 got %h exp %h", result_mtx, ji);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop_busy got %b exp 0", busy);
    end
    a_mtx = '0;
    b_mtx = '0;
  endtask

  task automatic test_reset_midrun();
    matrix_t id, h;
    int ndone, lat, bn;
    id    = mk(ONE, 0, 0, ONE, 0, 0, 0, 0);
    h     = mk(H0, H1, H2, -H3, 0, 0, 0, 0);
    a_mtx = id;
    b_mtx = id;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (result_mtx[0][0].re !== 37'(ONE)) begin
      n_fail++;
      $display("FAIL mid_c00_written got %0d exp %0d",
               result_mtx[0][0].re, ONE);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abort busy %b done %b exp 0 0",
               busy, done);
    end
    n_checks++;
    if (result_mtx !== '0) begin
      n_fail++;
      $display("FAIL mid_clear got %h exp 0", result_mtx);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL mid_no_done got %0d active cycles exp 0",
               ndone);
    end
    launch(id, h, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL mid_rerun_latency got %0d exp 9", lat);
    end
    n_checks++;
    if (result_mtx !== h) begin
      n_fail++;
      $display("FAIL mid_rerun_result got %h exp %h",
               result_mtx, h);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_identity();
    test_hadamard();
    test_saturation();
    test_complex();
    test_handshake();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtx_mult_sequencer.md
# mtx_mult_sequencer

Sequences one shared complex multiplier to compute the product of two 2×2 complex matrices of Q1.35 numbers. It sits behind the coordinator, which latches the operand matrices received over the UART and pulses `start`. The block then issues the 8 complex products in a fixed order, accumulates pairs, and returns the saturated 2×2 result with a one-cycle `done` pulse. The coordinator serializes that result back out.

## Interface
- `NUMBER_BITS`, 37, width of one real number (signed, Q1.35)
- `FRAC_BITS`, 35, fractional bits; the product rescale shift
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; one clock domain
- `start`  in  1  request; sampled only in IDLE
- `a_mtx`  in  `matrix_t` (296)  left operand, `[row][col]{re,im}`
- `b_mtx`  in  `matrix_t` (296)  right operand
- `busy`  out  1  high while RUN
- `done`  out  1  one-cycle pulse when `result_mtx` is complete
- `result_mtx`  out  `matrix_t` (296)  product C = A·B

## Operation
- States: IDLE, RUN. Step counter `k` is 4 bits, covering 0..8.
- In IDLE, `start`=1 at an edge:
  - latches `a_mtx`/`b_mtx` into internal operand registers,
  - sets k=0 and moves to RUN.
  - Inputs are ignored after this latch.
- Step k=0..7 maps to element e=k[2:1] (row=e[1], col=e[0]) and term t=k[0].
  - Issued operands are A[row][t] and B[t][col].
- Complex product, at full precision (74-bit terms, 76-bit sum):
  - re = ar·br − ai·bi
  - im = ar·bi + ai·br
- Accumulate:
  - t=0: acc ← P.
  - t=1: C[e] ← sat((acc + P) >>> FRAC_BITS).
- Shift is arithmetic, i.e. floor toward −∞.
- sat clamps to [−2^36, 2^36−1] independently for re and im.
- `start` during RUN is ignored: not queued, no effect.
- `result_mtx` is written one element at a time during RUN. It is valid only from the `done` cycle until the next accepted start.

## Timing
- Reset values: state=IDLE, k=0, `busy`=0, `done`=0, `result_mtx`=0. Operand and accumulator registers are also cleared.
- Reset mid-RUN: abort immediately. No `done` is produced and the partial result is cleared.
- Let E0 be the edge that accepts `start`.
  - E1..E8: product register P ← product(step k); k increments.
  - E2..E9: accumulate/write for step k−1.
  - C[0][0] is written at E3, C[0][1] at E5, C[1][0] at E7, C[1][1] at E9.
  - E9: state → IDLE, `done` ← 1.
  - E10: `done` ← 0.
- `busy` is high for the 9 cycles between E0 and E9.
- Latency is 9 cycles from start acceptance to `done`.
- `start` high during the `done` cycle is accepted at E10, giving back-to-back runs with one idle cycle. Throughput is 1 result per 10 cycles.
- A held `start` restarts at every opportunity.
- Multiplier: one registered stage, so the P register is inside the sub-module. No multicycle paths are required.

## Structure
- Shared package `quantum_pkg`:
  - `NUMBER_BITS`, `FRAC_BITS`
  - `number_t` (`logic signed [36:0]`)
  - `cnum_t` (packed struct `{re, im}`)
  - `matrix_t` (`cnum_t [0:1][0:1]`)
  - saturation function `sat_number`
- Sub-module `complex_mul`:
  - clk, reset, operands x, y (`cnum_t`), registered full-precision product out (2×74-bit signed).
  - Four real multipliers and one output register; no control logic.
- The sequencer holds the FSM, step counter, operand registers, accumulator, rescale/saturate logic and result register.

## Test plan
- **Identity:** A=B=I (re diagonal = 34359738368, all else 0), start → `done` exactly 9 cycles after acceptance. `result_mtx` = I exactly; `busy` high 9 cycles.
- **Hadamard-like:** A=B = {{24296004000, 24296004001}, {24296004002, −24296004003}}, imag 0 → C re = {{34359738370, −3}, {−3, 34359738374}}, all imag 0.
- **Saturation:** all A, B re = 68719476735, imag 0 → every C re = 68719476735 and imag 0. Repeat with B re = −68719476736 → every C re = −68719476736.
- **Complex arithmetic:**
  - A = j·I (im diagonal = 2^35), B = j·I → C = −I: re diagonal = −34359738368, everything else 0.
  - A = I, B = j·I → C im diagonal = 34359738368, everything else 0.
- **Handshake:** start pulsed again at E3 → ignored, single `done`. Start held high through `done` → second run accepted at E10, second `done` 9 cycles later.
- **Reset mid-run:** reset asserted between E4 and E5 → `busy`, `done` and `result_mtx` are 0 immediately (asynchronously) and no `done` follows. A new start after deassertion completes normally.
